// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline controller for the 5-stage RV32I core.
//
// Drives hold/clear controls for the F/D, D/E, E/M and M/W stage registers
// and the E-stage ALU operand forwarding selects. Handles load-use bubbles,
// taken-branch/jump redirects and multi-cycle data-memory waits. A watchdog
// moves to a sticky FAULT state when a memory access waits too long.
//
// Optional feature macro: HAZARD_PERF_EN (adds StallCnt/FlushCnt/WaitCnt).
//
// Ports:
//   clk, rst                clock (rising edge), async reset active-low
//   Rs1D, Rs2D              source regs of instruction in D
//   Rs1E, Rs2E, RdE         source/dest regs of instruction in E
//   ResultSrcE0             instruction in E is a load
//   PCSrcE                  branch taken / jump resolved in E
//   RdM, RdW                dest regs in M and W
//   RegWriteM, RegWriteW    write enables in M and W
//   MemReqM, MemAckM        data-memory request / completion in M
//   StallF/D/E/M            hold stage register
//   FlushD, FlushE          synchronous clear of D and E stage registers
//   ForwardAE, ForwardBE    00 regfile, 01 W result, 10 M ALU result
//   Fault                   sticky memory-timeout flag
//   StallCnt/FlushCnt/WaitCnt  saturating perf counters (HAZARD_PERF_EN)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic                      ResultSrcE0,
    input  logic                      PCSrcE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      MemReqM,
    input  logic                      MemAckM,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      Fault
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]      StallCnt,
    output logic [CNT_WIDTH-1:0]      FlushCnt,
    output logic [CNT_WIDTH-1:0]      WaitCnt
`endif
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0] state, state_nxt;
    logic [7:0] wcnt, wcnt_nxt;

    logic lw_stall, mem_wait;
    logic run_rules;         // this cycle is resolved by the RUN priority rules
    logic bubble, br_flush;  // which RUN rule fired (feeds perf counters)

    // M has priority over W; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        if (RegWriteM && RdM != '0 && RdM == rs)      return 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == rs) return 2'b01;
        else                                          return 2'b00;
    endfunction

    assign lw_stall = ResultSrcE0 && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);
    assign mem_wait = MemReqM && !MemAckM;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = fwd_sel(Rs1E);
        ForwardBE = fwd_sel(Rs2E);
        state_nxt = state;
        wcnt_nxt  = wcnt;
        run_rules = 1'b0;
        bubble    = 1'b0;
        br_flush  = 1'b0;

        case (state)
            S_FAULT: begin
                {StallF, StallD, StallE, StallM} = 4'b1111;
            end
            S_WAIT: begin
                if (mem_wait) begin
                    // A pending PCSrcE stays in the frozen E register.
                    {StallF, StallD, StallE, StallM} = 4'b1111;
                    wcnt_nxt = wcnt + 8'd1;
                    if (wcnt == 8'(MEM_TIMEOUT - 1)) state_nxt = S_FAULT;
                end else begin
                    // Ack cycle resolves with RUN rules immediately.
                    run_rules = 1'b1;
                    state_nxt = S_RUN;
                    wcnt_nxt  = 8'd0;
                end
            end
            default: run_rules = 1'b1;
        endcase

        if (run_rules) begin
            if (mem_wait) begin
                {StallF, StallD, StallE, StallM} = 4'b1111;
                state_nxt = S_WAIT;
                wcnt_nxt  = 8'd1;
            end else if (PCSrcE) begin
                // Redirect wins over load-use: the D instruction is discarded.
                FlushD   = 1'b1;
                FlushE   = 1'b1;
                br_flush = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                bubble = 1'b1;
            end
        end

        // Reset holds the pipeline cleared, not frozen.
        if (!rst) begin
            {StallF, StallD, StallE, StallM} = 4'b0000;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
            bubble    = 1'b0;
            br_flush  = 1'b0;
        end
    end

    assign Fault = (state == S_FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
            wcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
            WaitCnt  <= '0;
        end else begin
            if (bubble && StallCnt != '1)            StallCnt <= StallCnt + 1'b1;
            if (br_flush && FlushCnt != '1)          FlushCnt <= FlushCnt + 1'b1;
            if (state == S_WAIT && WaitCnt != '1)    WaitCnt  <= WaitCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, Fault;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt, FlushCnt, WaitCnt;
`endif

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemAckM(MemAckM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Fault(Fault)
`ifdef HAZARD_PERF_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .WaitCnt(WaitCnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,FwdA,FwdB,Fault}
    localparam logic [10:0] ZERO  = 11'b0000_00_00_00_0;
    localparam logic [10:0] RSTV  = 11'b0000_11_00_00_0;
    localparam logic [10:0] LWS   = 11'b1100_01_00_00_0;
    localparam logic [10:0] BR    = 11'b0000_11_00_00_0;
    localparam logic [10:0] STALL = 11'b1111_00_00_00_0;
    localparam logic [10:0] FLT   = 11'b1111_00_00_00_1;

    typedef struct {
        string       nm;
        logic [10:0] v;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: outputs are combinational, sampled at the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.nm, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE,
                             ForwardAE, ForwardBE, Fault}), 32'(e.v));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [10:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
    endtask

    task automatic clr_in();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM} = '0;
    endtask

    initial begin
        rst = 1'b0;
        clr_in();

        // Reset state, and reset dominating an active memory wait
        nxt(); expect_out("reset", RSTV);
        nxt(); MemReqM = 1'b1; PCSrcE = 1'b1; expect_out("reset_hold", RSTV);
        nxt(); rst = 1'b1; clr_in(); expect_out("idle", ZERO);

        // Load-use on Rs1D, then clear, then Rs2D, then x0
        nxt(); ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; expect_out("lw_rs1", LWS);
        nxt(); ResultSrcE0 = 1'b0; expect_out("lw_clear", ZERO);
        nxt(); ResultSrcE0 = 1'b1; Rs1D = 5'd0; Rs2D = 5'd5; expect_out("lw_rs2", LWS);
        nxt(); RdE = 5'd0; Rs2D = 5'd0; expect_out("lw_x0", ZERO);
        nxt(); clr_in(); expect_out("idle2", ZERO);

        // Forwarding priority
        nxt(); RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7;
        expect_out("fwd_m", 11'b0000_00_10_00_0);
        nxt(); RdM = 5'd0; expect_out("fwd_w", 11'b0000_00_01_00_0);
        nxt(); Rs1E = 5'd0; expect_out("fwd_x0", ZERO);
        nxt(); RegWriteM = 1'b0; RdM = 5'd9; RdW = 5'd9; Rs2E = 5'd9;
        expect_out("fwdb_w", 11'b0000_00_00_01_0);
        nxt(); RegWriteM = 1'b1; Rs1E = 5'd9; expect_out("fwdab_m", 11'b0000_00_10_10_0);
        nxt(); clr_in(); expect_out("idle3", ZERO);

        // Branch overrides load-use
        nxt(); PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        expect_out("br_over_lw", BR);
        nxt(); clr_in(); expect_out("idle4", ZERO);

        // Memory wait with a pending redirect
        for (int i = 1; i <= 3; i++) begin
            nxt(); MemReqM = 1'b1; MemAckM = 1'b0; PCSrcE = 1'b1;
            expect_out($sformatf("memwait%0d", i), STALL);
        end
        nxt(); MemAckM = 1'b1; expect_out("mem_ack", BR);
        nxt(); clr_in(); expect_out("after_ack", ZERO);
        nxt(); MemAckM = 1'b1; expect_out("ack_noreq", ZERO);

        // Timeout watchdog
        for (int i = 1; i <= 16; i++) begin
            nxt(); MemReqM = 1'b1; MemAckM = 1'b0;
            expect_out($sformatf("tmo_stall%0d", i), STALL);
        end
        nxt(); expect_out("fault_rise", FLT);
        nxt(); MemAckM = 1'b1; expect_out("fault_sticky", FLT);
        nxt(); MemReqM = 1'b0; MemAckM = 1'b0; PCSrcE = 1'b1; expect_out("fault_ignore", FLT);

        nxt();
`ifdef HAZARD_PERF_EN
        check("stallcnt", StallCnt, 32'd2);
        check("flushcnt", FlushCnt, 32'd2);
        check("waitcnt", WaitCnt, 32'd18);
`endif
        rst = 1'b0; expect_out("fault_rst", RSTV);
        nxt(); rst = 1'b1; clr_in(); expect_out("post_fault_run", ZERO);

        // Async reset mid memory wait
        nxt(); MemReqM = 1'b1; expect_out("aw_stall1", STALL);
        nxt(); expect_out("aw_stall2", STALL);
        nxt(); #2; rst = 1'b0; expect_out("async_rst", RSTV);
        #1;
`ifdef HAZARD_PERF_EN
        check("stallcnt_rst", StallCnt, 32'd0);
        check("flushcnt_rst", FlushCnt, 32'd0);
        check("waitcnt_rst", WaitCnt, 32'd0);
`endif
        nxt(); rst = 1'b1; clr_in(); expect_out("aw_run", ZERO);
        nxt(); MemReqM = 1'b1; expect_out("aw_stall3", STALL);
        nxt(); MemAckM = 1'b1; expect_out("aw_ack", ZERO);
        nxt(); clr_in(); expect_out("final", ZERO);

        begin
            int budget = 20;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV32I core. It generates stall/flush/enable controls for the F/D, D/E, E/M and M/W pipeline registers, and forwarding selects for the E-stage ALU operands.
- Handles load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits, with a timeout watchdog.
- Sits beside the datapath. All stage registers take their enable and clear from this block.

Parameters:
- REG_ADDR_WIDTH, 5, register-file address width.
- MEM_TIMEOUT, 16, max consecutive wait cycles before fault (legal range 2..255).
- CNT_WIDTH, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source regs of instruction in D.
- Rs1E, Rs2E  in  REG_ADDR_WIDTH  source regs of instruction in E.
- RdE  in  REG_ADDR_WIDTH  destination reg in E.
- ResultSrcE0  in  1  instruction in E is a load.
- PCSrcE  in  1  branch taken / jump resolved in E.
- RdM, RdW  in  REG_ADDR_WIDTH  destination regs in M and W.
- RegWriteM, RegWriteW  in  1  write-enable of instructions in M and W.
- MemReqM  in  1  data-memory access in M.
- MemAckM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding stage register.
- FlushD, FlushE  out  1  synchronous clear of the D and E stage registers.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result.
- Fault  out  1  sticky memory-timeout flag.

Behaviour:
- Forwarding is combinational in every state.
  - ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Else ForwardAE = 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE uses the same rule with Rs2E. M has priority over W.
- lwStall = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
- memWait = MemReqM && !MemAckM.
- FSM states, registered: RUN, MEM_WAIT, FAULT. A wait counter, 8 bits, is registered alongside the state.
- RUN:
  - If memWait: all four stalls = 1, FlushD = FlushE = 0. Next state MEM_WAIT, counter = 1.
  - Else if PCSrcE: FlushD = FlushE = 1, all stalls = 0. The branch overrides lwStall because the D instruction is discarded.
  - Else if lwStall: StallF = StallD = 1, FlushE = 1 (bubble), StallE = StallM = 0.
  - Else all outputs = 0.
- MEM_WAIT:
  - While memWait: all stalls = 1, flushes = 0 (a pending PCSrcE is held in the stalled E register). Counter increments each cycle.
  - If counter == MEM_TIMEOUT - 1 and memWait is still high: next state FAULT.
  - When MemAckM = 1: outputs are evaluated with the RUN rules in that same cycle. Next state RUN, counter = 0.
- FAULT:
  - All stalls = 1, flushes = 0, Fault = 1.
  - Only reset exits this state. Inputs are ignored.
- Stall/flush outputs are combinational from state and inputs. There is no added latency: a hazard seen in cycle N acts at the edge ending cycle N.
- Reset (rst = 0, asynchronous):
  - state = RUN, counter = 0, Fault = 0.
  - While rst = 0: all stalls = 0, FlushD = FlushE = 1, Forward* = 00.
  - Reset mid-MEM_WAIT or in FAULT returns to RUN on release.
- MemAckM with MemReqM = 0 is ignored.
- x0 is never forwarded and never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs StallCnt, FlushCnt and WaitCnt, each CNT_WIDTH wide.
  - StallCnt increments on each cycle lwStall causes a bubble.
  - FlushCnt increments on each cycle PCSrcE causes a flush.
  - WaitCnt increments on each cycle in MEM_WAIT.
  - Counters saturate at all-ones and are cleared by reset.
- Undefined: the ports and the counter logic are absent.
- Control behaviour is identical either way.

Test Plan:
- Load-use: ResultSrcE0 = 1, RdE = 5, Rs1D = 5 for one cycle -> StallF = StallD = FlushE = 1 for exactly that cycle, StallE = StallM = 0. Next cycle (ResultSrcE0 = 0) all = 0.
- Forward priority: RegWriteM = RegWriteW = 1, RdM = RdW = Rs1E = 7 -> ForwardAE = 10. Set RdM = 0 -> ForwardAE = 01. Set Rs1E = 0 -> ForwardAE = 00.
- Branch vs load-use: PCSrcE = 1 with lwStall true -> FlushD = FlushE = 1, StallF = StallD = 0.
- Memory wait: MemReqM = 1, MemAckM = 0 for 3 cycles, then MemAckM = 1 -> all stalls high for 3 cycles, low on the ack cycle, state RUN afterwards. With PCSrcE = 1 held throughout, FlushD/E assert only on the ack cycle.
- Timeout: MemReqM = 1, MemAckM never asserted, MEM_TIMEOUT = 16 -> Fault rises after 16 stalled cycles and stays high after MemAckM = 1. rst pulse -> Fault = 0, state RUN.
- Async reset: assert rst low between clock edges during MEM_WAIT -> outputs go immediately to stalls = 0, FlushD = FlushE = 1. With HAZARD_PERF_EN defined, all counters read 0.
